// File: rtl/sd_pkg.sv
// Elaboration-time helpers for the parametrised serial pattern detector:
// state width, KMP failure table and the full next-state table.
package sd_pkg;

  localparam int SD_MAX_LEN = 16;
  localparam int SD_IDX_W   = 5;
  localparam logic [SD_IDX_W-1:0] SD_S0 = '0;

  typedef logic [SD_MAX_LEN:0][SD_IDX_W-1:0]        sd_fail_t;
  typedef logic [SD_MAX_LEN:0][1:0][SD_IDX_W-1:0]   sd_next_t;

  function automatic int sd_state_w(input int pat_len);
    return $clog2(pat_len + 1);
  endfunction

  // Bit k of the pattern counted from the first-received (MSB) end.
  function automatic logic sd_pat_bit(input logic [15:0] pat, input int len, input int k);
    return 1'(pat >> (len - 1 - k));
  endfunction

  // f[k] = longest proper prefix of PATTERN that is also a suffix of its first k bits.
  function automatic sd_fail_t sd_fail_table(input logic [15:0] pat, input int len);
    sd_fail_t f;
    int       j;
    f = '0;
    for (int i = 1; i < SD_MAX_LEN; i++) begin
      if (i < len) begin
        j = int'(f[i]);
        for (int n = 0; n < SD_MAX_LEN; n++) begin
          if (j > 0 && sd_pat_bit(pat, len, i) != sd_pat_bit(pat, len, j)) j = int'(f[j]);
        end
        if (sd_pat_bit(pat, len, i) == sd_pat_bit(pat, len, j)) j++;
        f[i+1] = SD_IDX_W'(j);
      end
    end
    return f;
  endfunction

  function automatic sd_next_t sd_next_table(input logic [15:0] pat, input int len,
                                             input sd_fail_t f);
    sd_next_t t;
    int       j;
    logic     done;
    t = '0;
    for (int k = 0; k < SD_MAX_LEN; k++) begin
      for (int b = 0; b < 2; b++) begin
        if (k < len) begin
          j    = k;
          done = 1'b0;
          for (int n = 0; n <= SD_MAX_LEN; n++) begin
            if (!done) begin
              if (sd_pat_bit(pat, len, j) == 1'(b)) begin
                j++;
                done = 1'b1;
              end else if (j == 0) begin
                done = 1'b1;
              end else begin
                j = int'(f[j]);
              end
            end
          end
          t[k][b] = SD_IDX_W'(j);
        end
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/sd_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sd_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/sd_pattern_moore.sv
// Parametrised Moore serial-pattern detector with run-time overlap select.
// SD_MATCH_CNT_EN adds the match_cnt port and its saturating counter.
//
//   state      | meaning
//   S0         | no pattern bits matched
//   Sk (k<LEN) | first k pattern bits matched
//   DET        | full pattern matched, dout = 1
module sd_pattern_moore
  import sd_pkg::*;
#(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             din,
  input  logic             overlap,
  output logic             dout
`ifdef SD_MATCH_CNT_EN
  ,output logic [CNT_W-1:0] match_cnt
`endif
);

  localparam int             SW   = sd_state_w(PAT_LEN);
  localparam logic [SW-1:0]  DET  = SW'(PAT_LEN);
  localparam sd_fail_t       FAIL = sd_fail_table(16'(PATTERN), PAT_LEN);
  localparam sd_next_t       NXT  = sd_next_table(16'(PATTERN), PAT_LEN, FAIL);

  logic [SW-1:0]       state_q, state_d;
  logic                dout_q, dout_d;
  logic [SD_IDX_W-1:0] k_idx;

  // DET behaves like S(f) or S0 depending on overlap, so it reuses the Sk rows.
  always_comb begin
    state_d = state_q;
    k_idx   = SD_S0;
    if (state_q == DET)     k_idx = overlap ? FAIL[PAT_LEN] : SD_S0;
    else if (state_q < DET) k_idx = SD_IDX_W'(state_q);
    if (state_q > DET)      state_d = SW'(SD_S0);
    else if (en)            state_d = SW'(NXT[k_idx][din]);
    dout_d = (state_d == DET);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SW'(SD_S0);
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
    end
  end

  assign dout = dout_q;

`ifdef SD_MATCH_CNT_EN
  logic cnt_inc;
  assign cnt_inc = en && (state_d == DET);

  sd_sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (cnt_inc),
    .cnt   (match_cnt)
  );
`endif

endmodule

// File: tb/tb_sd_pattern_moore.sv
// Directed bench for sd_pattern_moore: default 1011, 1111 and a 2-bit counter instance.
module tb_sd_pattern_moore;

  logic clk;
  logic rst_def, en_def, din_def, ov_def, dout_def;
  logic rst_one, en_one, din_one, ov_one, dout_one;
  logic rst_sat, en_sat, din_sat, ov_sat, dout_sat;
`ifdef SD_MATCH_CNT_EN
  logic [7:0] cnt_def;
  logic [7:0] cnt_one;
  logic [1:0] cnt_sat;
`endif

  int checks = 0;
  int errors = 0;

  sd_pattern_moore u_def (
    .clk(clk), .reset(rst_def), .en(en_def), .din(din_def), .overlap(ov_def), .dout(dout_def)
`ifdef SD_MATCH_CNT_EN
    , .match_cnt(cnt_def)
`endif
  );

  sd_pattern_moore #(.PAT_LEN(4), .PATTERN(4'b1111), .CNT_W(8)) u_one (
    .clk(clk), .reset(rst_one), .en(en_one), .din(din_one), .overlap(ov_one), .dout(dout_one)
`ifdef SD_MATCH_CNT_EN
    , .match_cnt(cnt_one)
`endif
  );

  sd_pattern_moore #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(2)) u_sat (
    .clk(clk), .reset(rst_sat), .en(en_sat), .din(din_sat), .overlap(ov_sat), .dout(dout_sat)
`ifdef SD_MATCH_CNT_EN
    , .match_cnt(cnt_sat)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic dout_of(input int sel);
    case (sel)
      0:       return dout_def;
      1:       return dout_one;
      default: return dout_sat;
    endcase
  endfunction

  // Drive one cycle on the selected instance; the others see en=0.
  task automatic drive(input int sel, input logic e, input logic b);
    en_def = 1'b0; en_one = 1'b0; en_sat = 1'b0;
    case (sel)
      0:       begin en_def = e; din_def = b; end
      1:       begin en_one = e; din_one = b; end
      default: begin en_sat = e; din_sat = b; end
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic run_bits(input int sel, input logic [15:0] bits, input logic [15:0] exp,
                          input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      drive(sel, 1'b1, bits[i]);
      check($sformatf("%s_b%0d", tag, n - i), 32'(dout_of(sel)), 32'(exp[i]));
    end
  endtask

  task automatic pulse_reset(input int sel);
    case (sel)
      0:       rst_def = 1'b0;
      1:       rst_one = 1'b0;
      default: rst_sat = 1'b0;
    endcase
    #2;
    rst_def = 1'b1; rst_one = 1'b1; rst_sat = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_def = 1'b0; rst_one = 1'b0; rst_sat = 1'b0;
    en_def = 1'b0; en_one = 1'b0; en_sat = 1'b0;
    din_def = 1'b0; din_one = 1'b0; din_sat = 1'b0;
    ov_def = 1'b1; ov_one = 1'b1; ov_sat = 1'b0;
    #1;
    check("rst_dout_def", 32'(dout_def), 32'd0);
    check("rst_dout_one", 32'(dout_one), 32'd0);
`ifdef SD_MATCH_CNT_EN
    check("rst_cnt_def", 32'(cnt_def), 32'd0);
`endif
    #3;
    rst_def = 1'b1; rst_one = 1'b1; rst_sat = 1'b1;

    // overlapping 1011 stream
    run_bits(0, 16'b1011011, 16'b0001001, 7, "ov1");
`ifdef SD_MATCH_CNT_EN
    check("ov1_cnt", 32'(cnt_def), 32'd2);
`endif

    // non-overlapping: second 1011 is not seen; trailing 011 proves the return to S1
    pulse_reset(0);
    ov_def = 1'b0;
    run_bits(0, 16'b1011011, 16'b0001000, 7, "ov0");
`ifdef SD_MATCH_CNT_EN
    check("ov0_cnt", 32'(cnt_def), 32'd1);
`endif
    run_bits(0, 16'b011, 16'b001, 3, "ov0_s1");

    // en gaps with din=1 must be ignored, and DET holds while en=0
    pulse_reset(0);
    run_bits(0, 16'b101, 16'b000, 3, "gap_pre");
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b0, 1'b1);
      check($sformatf("gap_lo%0d", i), 32'(dout_def), 32'd0);
    end
    run_bits(0, 16'b1, 16'b1, 1, "gap_fin");
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b0, 1'b1);
      check($sformatf("gap_hold%0d", i), 32'(dout_def), 32'd1);
    end
`ifdef SD_MATCH_CNT_EN
    check("gap_cnt", 32'(cnt_def), 32'd1);
`endif

    // async reset while in DET clears dout without a clock edge
    ov_def = 1'b1;
    #3;
    rst_def = 1'b0;
    #1;
    check("rst_det_dout", 32'(dout_def), 32'd0);
    rst_def = 1'b1;

    // async reset in S3 (1011 01 with overlap), then no residual match
    run_bits(0, 16'b101101, 16'b000100, 6, "rst_s3");
    #3;
    rst_def = 1'b0;
    #1;
    check("rst_s3_dout", 32'(dout_def), 32'd0);
`ifdef SD_MATCH_CNT_EN
    check("rst_s3_cnt", 32'(cnt_def), 32'd0);
`endif
    rst_def = 1'b1;
    run_bits(0, 16'b1011, 16'b0001, 4, "rst_after");

    // 1111 with overlap: three consecutive detect cycles
    run_bits(1, 16'b111111, 16'b000111, 6, "ones_ov1");
`ifdef SD_MATCH_CNT_EN
    check("ones_ov1_cnt", 32'(cnt_one), 32'd3);
`endif
    pulse_reset(1);
    ov_one = 1'b0;
    run_bits(1, 16'b111111, 16'b000100, 6, "ones_ov0");
`ifdef SD_MATCH_CNT_EN
    check("ones_ov0_cnt", 32'(cnt_one), 32'd1);
`endif

    // 2-bit counter saturates at 3 over five back-to-back matches
    for (int m = 0; m < 5; m++) begin
      run_bits(2, 16'b1011, 16'b0001, 4, $sformatf("sat_m%0d", m));
`ifdef SD_MATCH_CNT_EN
      check($sformatf("sat_cnt%0d", m), 32'(cnt_sat), (m < 3) ? 32'(m + 1) : 32'd3);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
